shift_row_collector: RTL and testbench
======================================

# shift_row_collector

Byte-serial AES forward ShiftRows stage for the encryption datapath. Collects a 16-byte AES state from the byte-wide data-communication link with a valid/ready handshake and applies the FIPS-197 forward ShiftRows permutation. It presents the result as a registered 128-bit block with its own valid/ready handshake. The output register is independent of the collection buffer, so block N+1 can be collected while block N waits for the consumer.

## Interface
- None (no parameters; block size fixed at 16 bytes).

- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- inData  input  8  incoming state byte.
- inValid  input  1  inData is valid this cycle.
- inReady  output  1  block accepts inData this cycle; a byte transfers when inValid && inReady.
- flush  input  1  discard the partially collected block.
- outputData  output  128  ShiftRows result; byte 0 at [127:120], byte 15 at [7:0].
- outValid  output  1  outputData holds a block not yet taken.
- outReady  input  1  consumer takes outputData; a block transfers when outValid && outReady.
- byteCount  output  4  number of bytes held in the collection buffer (0..15).

## Operation
- State byte order is column-major. Byte k = s[k mod 4][k div 4]. First byte received is byte 0.
- Forward ShiftRows: out[r][c] = in[r][(c+r) mod 4].
- Output byte order equals input bytes {0,5,10,15, 4,9,14,3, 8,13,2,7, 12,1,6,11}.
- Collection: byte k is written to buffer slot k, and byteCount increments.
- Each block is accepted in full, 16 bytes, before any permutation happens.
- Completion: when byteCount==15 and a byte is accepted, all of the following happen on that edge:
  - outputData <= ShiftRows(buffer[0..14], inData)
  - outValid <= 1
  - byteCount <= 0
- inReady rules:
  - inReady = 1 when byteCount<15.
  - When byteCount==15, inReady = (!outValid || outReady). The 16th byte therefore stalls only while an untaken block occupies the output register.
  - While reset is high, inReady = 0.
- Output drain: on outValid && outReady with no completion on the same edge, outValid <= 0. outputData keeps its last value.
- Simultaneous drain and completion: the new block loads and outValid stays 1. No bubble and no loss.
- flush:
  - On flush, byteCount <= 0 and any byte offered that cycle is dropped, even if inValid && inReady.
  - flush does not affect outputData or outValid.
  - flush has priority over completion.
- Reset:
  - outputData = 128'h0, outValid = 0, byteCount = 0.
  - Buffer contents are don't-care.
  - A block in progress or pending at reset is lost.
- Output stability: outputData and outValid do not change while outValid && !outReady.
- Control state: a 4-bit counter (COLLECTING, byteCount 0..15) plus an output-full flag (outValid). No other FSM states.

## Timing
- Latency: outValid rises on the clock edge that accepts the 16th byte and is visible the following cycle.
- That is 1 cycle from the last accepted byte to outputData/outValid.
- Throughput: one byte per clock sustained.
- With outReady held high, blocks emerge every 16 cycles with no stall.
- inReady depends combinationally on outReady only when byteCount==15. All other outputs are registered.
- Wrap-around: byteCount goes 15 -> 0 on completion and never reaches 16.

## Test plan
- FIPS-197 vector:
  - Stimulus: reset, then stream d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 back-to-back, outReady=1.
  - Required: one cycle after the 16th byte, outValid=1 and outputData = d4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Required: outValid returns to 0 the next cycle.
- Reset values:
  - Stimulus: hold reset 3 cycles with inValid=1.
  - Required: inReady=0, outValid=0, outputData=0, byteCount=0 throughout.
  - Required: inReady=1 on the first cycle after reset falls.
- Backpressure:
  - Stimulus: outReady=0, stream bytes 00..0f and then 10..1f.
  - Required: the first block is held stable as 00050a0f_04090e03_080d0207_0c01060b.
  - Required: byte 0x1f stalls with inReady=0 and byteCount=15.
  - Stimulus: raise outReady for 1 cycle.
  - Required: 0x1f is accepted that cycle, and the next cycle shows outValid=1 with outputData = 10151a1f_14191e13_181d1217_1c11161b.
- Flush:
  - Stimulus: send 7 bytes, pulse flush together with an 8th byte (inValid=1), then send 00..0f.
  - Required: byteCount=0 after the flush edge and the 8th byte is dropped.
  - Required: output equals 00050a0f_04090e03_080d0207_0c01060b.
- Simultaneous drain and completion:
  - Stimulus: outValid=1 from a prior block, and the 16th byte of the next block is accepted in the same cycle as outReady=1.
  - Required: outValid stays 1 and outputData updates to the new block on that edge.
- Mid-block reset:
  - Stimulus: send 9 bytes, assert reset for 1 cycle, then send a full vector.
  - Required: the output equals the permutation of the new 16 bytes only, and byteCount=0 right after reset.

Source files
------------

// File: rtl/shift_row_collector.sv
// Byte-serial AES forward ShiftRows: collects a 16-byte column-major state and emits the
// permuted block through a registered output with its own valid/ready handshake.
module shift_row_collector (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   inData,
  input  logic         inValid,
  output logic         inReady,
  input  logic         flush,
  output logic [127:0] outputData,
  output logic         outValid,
  input  logic         outReady,
  output logic [3:0]   byteCount
);

  logic [7:0]   bufferQ [15];
  logic [7:0]   fullBlock [16];
  logic [3:0]   countQ;
  logic         outValidQ;
  logic [127:0] outDataQ;
  logic [127:0] shifted;
  logic         lastSlot;
  logic         accept;
  logic         complete;

  assign lastSlot = (countQ == 4'd15);

  // The 16th byte only waits while an untaken block still occupies the output register.
  assign inReady  = !reset && (!lastSlot || !outValidQ || outReady);
  assign accept   = inValid && inReady && !flush;
  assign complete = accept && lastSlot;

  always_comb begin
    for (int k = 0; k < 15; k++) begin
      fullBlock[k] = bufferQ[k];
    end
    fullBlock[15] = inData;
  end

  // Output byte r+4c takes input byte r+4((c+r) mod 4); byte 0 lands in the top bits.
  always_comb begin
    shifted = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        shifted[8*(15-(r+4*c)) +: 8] = fullBlock[r + 4*((c+r) % 4)];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 15; i++) begin
      if (accept && (countQ == i[3:0])) begin
        bufferQ[i] <= inData;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      countQ    <= 4'd0;
      outValidQ <= 1'b0;
      outDataQ  <= '0;
    end else begin
      if (flush) begin
        countQ <= 4'd0;
      end else if (accept) begin
        countQ <= countQ + 4'd1;
      end

      if (complete) begin
        outDataQ  <= shifted;
        outValidQ <= 1'b1;
      end else if (outValidQ && outReady) begin
        outValidQ <= 1'b0;
      end
    end
  end

  assign outputData = outDataQ;
  assign outValid   = outValidQ;
  assign byteCount  = countQ;

endmodule

// File: tb/tb_shift_row_collector.sv
// Scoreboard bench for shift_row_collector: a byte-level model pushes expected blocks,
// the output monitor pops and compares them on every output transfer.
module tb_shift_row_collector;

  logic         clock;
  logic         reset;
  logic [7:0]   inData;
  logic         inValid;
  logic         inReady;
  logic         flush;
  logic [127:0] outputData;
  logic         outValid;
  logic         outReady;
  logic [3:0]   byteCount;

  int checks = 0;
  int errors = 0;
  int blocksSeen = 0;

  logic [127:0] expQ [$];
  logic [7:0]   coll [16];
  int           collN = 0;

  localparam logic [127:0] FipsOut = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] RampOut = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [127:0] Ramp2Out = 128'h10151a1f_14191e13_181d1217_1c11161b;

  shift_row_collector dut (
    .clock      (clock),
    .reset      (reset),
    .inData     (inData),
    .inValid    (inValid),
    .inReady    (inReady),
    .flush      (flush),
    .outputData (outputData),
    .outValid   (outValid),
    .outReady   (outReady),
    .byteCount  (byteCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] shiftRowsRef(input logic [7:0] b [16]);
    int order [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    logic [127:0] res;
    for (int j = 0; j < 16; j++) begin
      res[127-8*j -: 8] = b[order[j]];
    end
    return res;
  endfunction

  // Model and monitor, sampled on the falling edge, well away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      collN = 0;
    end else begin
      if (outValid && outReady) begin
        blocksSeen++;
        if (expQ.size() == 0) begin
          check("unexpected_block", outputData, 128'hx);
        end else begin
          check("scoreboard_block", outputData, expQ.pop_front());
        end
      end
      if (flush) begin
        collN = 0;
      end else if (inValid && inReady) begin
        coll[collN] = inData;
        collN++;
        if (collN == 16) begin
          expQ.push_back(shiftRowsRef(coll));
          collN = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    inValid = 1'b1;
    inData  = b;
    n = 0;
    @(negedge clock);
    while (!inReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!inReady) check("send_timeout", {127'd0, inReady}, 128'd1);
    tick();
    inValid = 1'b0;
  endtask

  task automatic sendBlock(input logic [7:0] b [16], input int count);
    for (int i = 0; i < count; i++) sendByte(b[i]);
  endtask

  logic [7:0] fips [16];
  logic [7:0] blkA [16];
  logic [7:0] blkB [16];

  initial begin
    fips = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
             8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    reset = 1'b1; inValid = 1'b1; inData = 8'h55; flush = 1'b0; outReady = 1'b0;

    // Reset values with inValid held high
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_inReady", {127'd0, inReady}, 128'd0);
      check("rst_outValid", {127'd0, outValid}, 128'd0);
      check("rst_outputData", outputData, 128'd0);
      check("rst_byteCount", {124'd0, byteCount}, 128'd0);
    end
    tick();
    reset = 1'b0;
    inValid = 1'b0;
    @(negedge clock);
    check("post_rst_inReady", {127'd0, inReady}, 128'd1);
    tick();

    // FIPS-197 vector, back-to-back, consumer always ready
    outReady = 1'b1;
    sendBlock(fips, 16);
    check("fips_valid", {127'd0, outValid}, 128'd1);
    check("fips_data", outputData, FipsOut);
    tick();
    check("fips_drained", {127'd0, outValid}, 128'd0);

    // Backpressure: first block held, 16th byte of second block stalls
    outReady = 1'b0;
    for (int i = 0; i < 16; i++) sendByte(8'(i));
    check("bp_valid", {127'd0, outValid}, 128'd1);
    check("bp_data", outputData, RampOut);
    for (int i = 16; i < 31; i++) begin
      sendByte(8'(i));
      check("bp_stable", outputData, RampOut);
    end
    check("bp_count15", {124'd0, byteCount}, 128'd15);
    inValid = 1'b1;
    inData  = 8'h1f;
    repeat (2) begin
      @(negedge clock);
      check("bp_stall_ready", {127'd0, inReady}, 128'd0);
      check("bp_stall_valid", {127'd0, outValid}, 128'd1);
      check("bp_stall_data", outputData, RampOut);
      tick();
    end
    outReady = 1'b1;
    @(negedge clock);
    check("bp_release_ready", {127'd0, inReady}, 128'd1);
    tick();
    outReady = 1'b0;
    inValid  = 1'b0;
    check("bp_second_valid", {127'd0, outValid}, 128'd1);
    check("bp_second_data", outputData, Ramp2Out);
    check("bp_count0", {124'd0, byteCount}, 128'd0);
    outReady = 1'b1;
    tick();
    check("bp_drained", {127'd0, outValid}, 128'd0);

    // Flush drops the partial block and the byte offered with it
    for (int i = 0; i < 7; i++) sendByte(8'(8'ha0 + i));
    check("flush_pre_count", {124'd0, byteCount}, 128'd7);
    inValid = 1'b1;
    inData  = 8'hff;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    inValid = 1'b0;
    check("flush_count", {124'd0, byteCount}, 128'd0);
    for (int i = 0; i < 16; i++) sendByte(8'(i));
    check("flush_data", outputData, RampOut);
    tick();

    // Simultaneous drain and completion
    for (int i = 0; i < 16; i++) begin
      blkA[i] = 8'($urandom);
      blkB[i] = 8'($urandom);
    end
    outReady = 1'b0;
    sendBlock(blkA, 16);
    check("sim_a_data", outputData, shiftRowsRef(blkA));
    sendBlock(blkB, 15);
    outReady = 1'b1;
    sendByte(blkB[15]);
    check("sim_valid_kept", {127'd0, outValid}, 128'd1);
    check("sim_b_data", outputData, shiftRowsRef(blkB));
    tick();
    check("sim_drained", {127'd0, outValid}, 128'd0);

    // Mid-block reset loses the partial block
    for (int i = 0; i < 9; i++) sendByte(8'(8'h70 + i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", {124'd0, byteCount}, 128'd0);
    sendBlock(fips, 16);
    check("mid_rst_data", outputData, FipsOut);
    tick();
    tick();

    check("blocks_seen", 128'(blocksSeen), 128'd7);
    check("scoreboard_empty", 128'(expQ.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
